// File: rtl/mu0_control_pkg.sv
// Shared encodings for the MU0 control sequencer: opcodes, ALU functions, FSM states.
package mu0_control_pkg;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    localparam logic [1:0] ALU_B   = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_INC = 2'b11;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // LDA, STA, ADD and SUB are the only execute steps that touch memory.
    function automatic logic is_mem_op(input logic [3:0] f);
        return (f[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/mu0_ack_timer.sv
// Counts cycles an access waits for MemAck; expired flags the last permitted wait cycle.
// TIMEOUT == 0 disables expiry; clr has priority over run.
module mu0_ack_timer #(
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned TIMEOUT_W = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (run)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (TIMEOUT != 0) && run && (cnt_q == LIMIT);

endmodule

// File: rtl/mu0_control.sv
// MU0 multi-cycle fetch/execute sequencer: decodes datapath strobes from state/opcode/flags
// and handshakes each memory access, halting on STP or on a MemAck timeout.
module mu0_control
    import mu0_control_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned TIMEOUT_W = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    input  logic       MemAck,
    output logic       AddrSel,
    output logic       BSel,
    output logic [1:0] ALUfs,
    output logic       ACCce,
    output logic       PCce,
    output logic       IRce,
    output logic       ACCoe,
    output logic       MEMrq,
    output logic       RnW,
    output logic       Halted,
    output logic       Fault
);

    state_t state_q, state_d;
    logic   fault_q, fault_d;
    logic   mem_rq, timer_clr, timer_run, expired;

    // Request decode kept apart from the main decode so the timer's expiry
    // does not feed back into the process that produces MEMrq.
    assign mem_rq = ~Reset & ((state_q == ST_FETCH) ||
                              ((state_q == ST_EXEC) && is_mem_op(F)));
    assign timer_clr = ~mem_rq | MemAck;
    assign timer_run = mem_rq & ~MemAck;

    mu0_ack_timer #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_ack_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .clr     (timer_clr),
        .run     (timer_run),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        AddrSel = 1'b0;
        BSel    = 1'b0;
        ALUfs   = ALU_B;
        ACCce   = 1'b0;
        PCce    = 1'b0;
        IRce    = 1'b0;
        ACCoe   = 1'b0;
        RnW     = 1'b0;
        if (!Reset) begin
            case (state_q)
                ST_FETCH: begin
                    RnW   = 1'b1;
                    BSel  = 1'b1;
                    ALUfs = ALU_INC;
                    IRce  = MemAck;
                    PCce  = MemAck;
                end
                ST_EXEC: begin
                    AddrSel = 1'b1;
                    state_d = ST_FETCH;
                    case (F)
                        OP_LDA: begin RnW = 1'b1; ALUfs = ALU_B;   ACCce = MemAck; end
                        OP_STA: begin ACCoe = 1'b1; end
                        OP_ADD: begin RnW = 1'b1; ALUfs = ALU_ADD; ACCce = MemAck; end
                        OP_SUB: begin RnW = 1'b1; ALUfs = ALU_SUB; ACCce = MemAck; end
                        OP_JMP: begin BSel = 1'b1; PCce = 1'b1; end
                        OP_JGE: begin BSel = 1'b1; PCce = ~N; end
                        OP_JNE: begin BSel = 1'b1; PCce = ~Z; end
                        OP_STP: state_d = ST_HALT;
                        default: ;
                    endcase
                end
                default: ;
            endcase
            // Memory cycles advance only on ack; the ack beats a same-cycle expiry.
            if (mem_rq) begin
                if (MemAck)
                    state_d = (state_q == ST_FETCH) ? ST_EXEC : ST_FETCH;
                else if (expired) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                end else
                    state_d = state_q;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_FETCH;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    assign MEMrq  = mem_rq;
    assign Halted = (state_q == ST_HALT);
    assign Fault  = fault_q;

endmodule

// File: tb/tb_mu0_control.sv
// Directed bench for mu0_control; outputs packed as
// {AddrSel,BSel,ALUfs,ACCce,PCce,IRce,ACCoe,MEMrq,RnW,Halted,Fault}.
module tb_mu0_control;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] F = 4'd0;
    logic       N = 1'b0;
    logic       Z = 1'b0;
    logic       MemAck = 1'b0;
    logic       AddrSel, BSel, ACCce, PCce, IRce, ACCoe, MEMrq, RnW, Halted, Fault;
    logic [1:0] ALUfs;
    logic [11:0] outv;

    int n_assert = 0;
    int n_fail   = 0;

    mu0_control #(.TIMEOUT(15), .TIMEOUT_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .MemAck(MemAck),
        .AddrSel(AddrSel), .BSel(BSel), .ALUfs(ALUfs), .ACCce(ACCce),
        .PCce(PCce), .IRce(IRce), .ACCoe(ACCoe), .MEMrq(MEMrq), .RnW(RnW),
        .Halted(Halted), .Fault(Fault)
    );

    always #5 Clk = ~Clk;

    assign outv = {AddrSel, BSel, ALUfs, ACCce, PCce, IRce, ACCoe, MEMrq, RnW, Halted, Fault};

    localparam logic [11:0] V_RESET   = 12'h000;
    localparam logic [11:0] V_FETCH   = 12'h70C;
    localparam logic [11:0] V_FETCH_A = 12'h76C;
    localparam logic [11:0] V_LDA_A   = 12'h88C;
    localparam logic [11:0] V_STA     = 12'h818;
    localparam logic [11:0] V_ADD     = 12'h90C;
    localparam logic [11:0] V_SUB_A   = 12'hA8C;
    localparam logic [11:0] V_JMP_T   = 12'hC40;
    localparam logic [11:0] V_JMP_N   = 12'hC00;
    localparam logic [11:0] V_EXEC0   = 12'h800;
    localparam logic [11:0] V_HALT    = 12'h002;
    localparam logic [11:0] V_FAULT   = 12'h003;

    task automatic check(input string tag, input logic [11:0] exp);
        n_assert++;
        assert (outv === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, outv, exp);
        end
    endtask

    // Drive inputs mid-cycle, then sample the combinational outputs 1 time unit later.
    task automatic step(input logic [3:0] f, input logic ack, input logic n, input logic z,
                        input logic [11:0] exp, input string tag);
        @(negedge Clk);
        F = f; MemAck = ack; N = n; Z = z;
        #1;
        check(tag, exp);
    endtask

    task automatic release_reset();
        @(posedge Clk);
        #2 Reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1 check("reset_outputs", V_RESET);
        release_reset();

        // Zero-wait LDA
        step(4'd0, 1'b1, 1'b0, 1'b0, V_FETCH_A, "lda_fetch");
        step(4'd0, 1'b1, 1'b0, 1'b0, V_LDA_A,   "lda_exec");
        step(4'd1, 1'b0, 1'b0, 1'b0, V_FETCH,   "lda_back_fetch");

        // STA with three wait cycles
        step(4'd1, 1'b1, 1'b0, 1'b0, V_FETCH_A, "sta_fetch");
        step(4'd1, 1'b0, 1'b0, 1'b0, V_STA,     "sta_wait1");
        step(4'd1, 1'b0, 1'b0, 1'b0, V_STA,     "sta_wait2");
        step(4'd1, 1'b0, 1'b0, 1'b0, V_STA,     "sta_wait3");
        step(4'd1, 1'b1, 1'b0, 1'b0, V_STA,     "sta_ack");

        // Conditional jumps and a reserved opcode
        step(4'd5, 1'b1, 1'b1, 1'b0, V_FETCH_A, "jge_n1_fetch");
        step(4'd5, 1'b0, 1'b1, 1'b0, V_JMP_N,   "jge_n1_exec");
        step(4'd5, 1'b1, 1'b0, 1'b0, V_FETCH_A, "jge_n0_fetch");
        step(4'd5, 1'b0, 1'b0, 1'b0, V_JMP_T,   "jge_n0_exec");
        step(4'd6, 1'b1, 1'b0, 1'b1, V_FETCH_A, "jne_z1_fetch");
        step(4'd6, 1'b0, 1'b0, 1'b1, V_JMP_N,   "jne_z1_exec");
        step(4'd4, 1'b1, 1'b1, 1'b1, V_FETCH_A, "jmp_fetch");
        step(4'd4, 1'b0, 1'b1, 1'b1, V_JMP_T,   "jmp_exec");
        step(4'd9, 1'b1, 1'b0, 1'b0, V_FETCH_A, "nop_fetch");
        step(4'd9, 1'b1, 1'b0, 1'b0, V_EXEC0,   "nop_exec");

        // STP, then MemAck in HALT, then reset recovery
        step(4'd7, 1'b1, 1'b0, 1'b0, V_FETCH_A, "stp_fetch");
        step(4'd7, 1'b0, 1'b0, 1'b0, V_EXEC0,   "stp_exec");
        step(4'd7, 1'b1, 1'b0, 1'b0, V_HALT,    "halt_ack_ignored1");
        step(4'd0, 1'b1, 1'b0, 1'b0, V_HALT,    "halt_ack_ignored2");
        Reset = 1'b1;
        #1 check("halt_reset_outputs", V_RESET);
        release_reset();

        // Timeout: 16 unanswered request cycles then HALT with Fault
        step(4'd0, 1'b0, 1'b0, 1'b0, V_FETCH, "to_wait0");
        for (int i = 1; i < 16; i++)
            step(4'd0, 1'b0, 1'b0, 1'b0, V_FETCH, "to_wait");
        step(4'd0, 1'b1, 1'b0, 1'b0, V_FAULT, "to_halt_fault");
        Reset = 1'b1;
        #1 check("fault_reset_outputs", V_RESET);
        release_reset();

        // Ack on the 16th request cycle wins over the limit
        for (int i = 0; i < 15; i++)
            step(4'd3, 1'b0, 1'b0, 1'b0, V_FETCH, "edge_wait");
        step(4'd3, 1'b1, 1'b0, 1'b0, V_FETCH_A, "edge_ack16");
        step(4'd3, 1'b1, 1'b0, 1'b0, V_SUB_A,   "edge_no_fault_sub");

        // Async reset mid-wait in ADD
        step(4'd2, 1'b1, 1'b0, 1'b0, V_FETCH_A, "add_fetch");
        step(4'd2, 1'b0, 1'b0, 1'b0, V_ADD,     "add_wait1");
        step(4'd2, 1'b0, 1'b0, 1'b0, V_ADD,     "add_wait2");
        #1 Reset = 1'b1;
        #1 check("add_reset_immediate", V_RESET);
        MemAck = 1'b1;
        #1 check("add_reset_ack_ignored", V_RESET);
        release_reset();

        // Wait counter restarted from zero: full 16 cycles before the fault
        for (int i = 0; i < 16; i++)
            step(4'd2, 1'b0, 1'b0, 1'b0, V_FETCH, "post_reset_wait");
        step(4'd2, 1'b0, 1'b0, 1'b0, V_FAULT, "post_reset_timeout");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
